// File: rtl/clk_step_ctrl.sv
// Clock-enable scheduler: turns HALT / STEP / DIV / FREE run modes into a one-cycle ce pulse.
// Define STEP_DEBOUNCE_EN to add a DB_CYCLES-long debounce filter on the step button.
module clk_step_ctrl #(
   parameter int          DIV_W       = 26,
   parameter int unsigned DIV_DEFAULT = 24000000,
   parameter logic [15:0] DB_CYCLES   = 16'd50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             step_btn,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             ce,
   output logic [15:0]      ce_count,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_STEP = 2'b01,
      S_DIV  = 2'b10,
      S_FREE = 2'b11
   } state_t;

   state_t           cur;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] pend_div;
   logic [DIV_W-1:0] eff_div;
   logic             pend_valid;
   logic             wrap;
   logic             sync1;
   logic             sync2;
   logic             step_lvl;
   logic             step_prev;
   logic             step_edge;

   assign state   = cur;
   assign eff_div = (div_reg <= DIV_W'(1)) ? DIV_W'(1) : div_reg;
   assign wrap    = (cur == S_DIV) && (cnt == eff_div - DIV_W'(1));

   // The edge pulse is registered so it never depends on the run mode; edges outside STEP just expire.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         step_prev <= 1'b0;
         step_edge <= 1'b0;
      end else begin
         sync1     <= step_btn;
         sync2     <= sync1;
         step_prev <= step_lvl;
         step_edge <= step_lvl & ~step_prev;
      end
   end

`ifdef STEP_DEBOUNCE_EN
   logic [15:0] db_cnt;

   // The filtered level flips only after DB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt   <= 16'd0;
         step_lvl <= 1'b0;
      end else if (sync2 != step_lvl) begin
         if (db_cnt == DB_CYCLES - 16'd1) begin
            db_cnt   <= 16'd0;
            step_lvl <= sync2;
         end else begin
            db_cnt <= db_cnt + 16'd1;
         end
      end else begin
         db_cnt <= 16'd0;
      end
   end
`else
   logic db_unused;
   assign db_unused = ^DB_CYCLES;
   assign step_lvl  = sync2;
`endif

   // A new divisor waits in pend_div until a period boundary; outside DIV every cycle is a boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur        <= S_HALT;
         ce         <= 1'b0;
         ce_count   <= 16'd0;
         cnt        <= '0;
         div_reg    <= DIV_W'(DIV_DEFAULT);
         pend_div   <= '0;
         pend_valid <= 1'b0;
         cfg_ready  <= 1'b1;
      end else begin
         cur      <= state_t'(mode);
         ce_count <= ce_count + {15'd0, ce};

         case (cur)
            S_HALT:  ce <= 1'b0;
            S_STEP:  ce <= step_edge;
            S_DIV:   ce <= wrap;
            default: ce <= 1'b1;
         endcase

         if ((cur != S_DIV) || wrap) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end

         if (cfg_valid && cfg_ready) begin
            pend_div   <= cfg_div;
            pend_valid <= 1'b1;
            cfg_ready  <= 1'b0;
         end else if (pend_valid) begin
            if ((cur != S_DIV) || wrap) begin
               div_reg    <= pend_div;
               pend_valid <= 1'b0;
            end
         end else if (!cfg_ready) begin
            cfg_ready <= 1'b1;
         end
      end
   end

endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Clock-enable scheduler for the CPU core. It replaces direct use of a divided clock with a single-cycle enable pulse `ce` on the system clock. It supports four run modes: halt, single-step from a push button, programmable divided rate, and full speed. The divisor is reprogrammed at runtime through a valid/ready handshake that takes effect only on a period boundary. The block sits between the board clock/buttons and every `ce`-gated register in the core.

## Interface
- `DIV_W`, 26: width of divisor and period counter.
- `DIV_DEFAULT`, 24000000: divisor loaded at reset.
- `DB_CYCLES`, 16'd50000: stable-cycle count for the step debounce (used only with `STEP_DEBOUNCE_EN`).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  00 HALT, 01 STEP, 10 DIV, 11 FREE.
- `step_btn`  in  1  raw push button, asynchronous to `clk`.
- `cfg_valid`  in  1  new divisor offered.
- `cfg_div`  in  DIV_W  offered divisor.
- `cfg_ready`  out  1  block can accept a divisor.
- `ce`  out  1  registered one-cycle enable pulse to the core.
- `ce_count`  out  16  number of `ce` pulses issued, wraps modulo 2^16.
- `state`  out  2  current state encoding, same as `mode`.

## Operation
- **State register.** `mode` is registered into `state` every cycle. States: S_HALT, S_STEP, S_DIV, S_FREE. Any state can move to any state directly; there are no intermediate states.
- **S_HALT.** `ce`=0.
- **S_FREE.** `ce`=1 every cycle.
- **S_DIV, counting.** `cnt` counts 0..`div_reg`-1. `ce` pulses for one cycle when `cnt`==`div_reg`-1, and `cnt` wraps to 0 on that cycle.
- **S_DIV, small divisors.** `div_reg` of 0 or 1 is treated as 1, giving `ce` every cycle.
- **S_DIV, entry.** Entering S_DIV from any other state clears `cnt` to 0. Leaving S_DIV discards any partial period.
- **Step synchronizer.** `step_btn` passes through a 2-flop synchronizer. The result, filtered when the debounce is compiled in, feeds a rising-edge detector.
- **S_STEP.** Each detected rising edge produces exactly one `ce` pulse. Holding the button produces no further pulses.
- **Step edges outside S_STEP.** Edges in any other state are discarded. The edge detector keeps tracking in every state, so entering S_STEP with the button already held produces no pulse.
- **Divisor handshake.**
  - Transfer occurs when `cfg_valid`&&`cfg_ready`: `cfg_div` is latched into `pend_div`, and `cfg_ready` drops the next cycle.
  - In S_DIV, `pend_div` moves into `div_reg` on the cycle that `ce` pulses (the wrap), so the next period uses the new value.
  - In any other state, `pend_div` moves into `div_reg` on the cycle after the transfer.
  - `cfg_ready` returns to 1 on the cycle after `div_reg` is updated.
  - `cfg_valid` while `cfg_ready`=0 is ignored and not queued.
- **Pulse counter.** `ce_count` increments on every cycle with `ce`=1 and wraps from 0xFFFF to 0.
- **Reset.** Asserting `rst` at any point forces the following values in the next cycle, regardless of state or handshake in progress:
  - `ce`=0, `ce_count`=0, `state`=00 (S_HALT)
  - `cfg_ready`=1, `cnt`=0, `div_reg`=`DIV_DEFAULT`
  - no pending divisor; synchronizer and edge detector flops all 0.

## Timing
- **Mode latency.** `mode` is sampled at edge t, so `state` updates at t. `ce` is registered from `state` and reflects the new mode at edge t+1.
- **DIV period.** After entering S_DIV with divisor N, the first `ce` comes N cycles after `state` becomes S_DIV. Pulses then repeat exactly every N cycles. `ce` is high for exactly one cycle.
- **Step latency, no debounce.** `ce` goes high exactly 3 cycles after the first edge that samples `step_btn`=1: 2 cycles of synchronizer, 1 cycle of registered output.
- **Step latency, debounce.** Add `DB_CYCLES` cycles to the step latency.
- **Handshake latency.**
  - Outside S_DIV, a transfer at edge t updates `div_reg` at t+1, and `cfg_ready`=1 again at t+2.
  - In S_DIV, `cfg_ready` stays 0 until the cycle after the next wrap.
- **Simultaneous events.** If a transfer happens on the same cycle as a wrap, the current wrap reloads the old `div_reg`. The new value applies from the following wrap.

## Configuration
- `STEP_DEBOUNCE_EN` defined:
  - The synchronized button level feeds a debounce counter.
  - The filtered level changes only after the raw synchronized level has differed from it for `DB_CYCLES` consecutive cycles.
  - Any mismatch-free cycle clears the count.
- `STEP_DEBOUNCE_EN` undefined:
  - The synchronized level feeds the edge detector directly.
  - `DB_CYCLES` is unused, and no debounce counter is synthesized.

## Test plan
- **FREE rate:** `rst`=1 for 2 cycles, then `mode`=11 → `ce`=1 every cycle from the 2nd cycle after release; `ce_count` reads 10 after 10 pulses.
- **DIV, boundary divisor update:** load `cfg_div`=4 while in S_HALT, then `mode`=10 → `ce` high 1 cycle in 4. With `div_reg`=10, transfer `cfg_div`=3 at `cnt`=3 → current period still ends at 10 cycles, then period is 3; `cfg_ready` low from the transfer until 1 cycle after that wrap.
- **Zero divisor:** `cfg_div`=0 in S_DIV → `ce` every cycle.
- **STEP:** in S_STEP, hold `step_btn`=1 for 20 cycles → exactly one `ce`, 3 cycles after the press. Enter S_STEP with the button already held → no `ce`.
- **Debounce:** with `STEP_DEBOUNCE_EN` and `DB_CYCLES`=8, a 5-cycle button glitch → no `ce`; a 12-cycle press → one `ce` at 3+8 cycles.
- **Reset mid-operation:** assert `rst` mid-period in S_DIV with a transfer pending → next cycle `ce`=0, `ce_count`=0, `state`=00, `cfg_ready`=1, `div_reg`=24000000.
